// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Definitions shared by the branch resolver and its testbench:
//   XLEN_DEFAULT  default PC width
//   INSN_BYTES    size of one instruction (fall-through step)
//   pred_entry_t  one queued prediction {pc, taken, target} at the default width
//   br_state_e    resolver FSM state
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int INSN_BYTES   = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic                    taken;
        logic [XLEN_DEFAULT-1:0] target;
    } pred_entry_t;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FLUSH  = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// -----------------------------------------------------------------------------
// branch_resolver_if
// Bundles the fetch-side prediction handshake, the execute-side resolution
// inputs and the flush/training results of the branch resolver.
//   master : fetch/execute side (drives pred_* and res_*, observes results)
//   slave  : the resolver itself
// Signals:
//   pred_valid/pred_ready/pred_pc/pred_taken/pred_target  prediction enqueue
//   res_valid/res_taken/res_target                        in-order resolution
//   flush/redirect_pc                                     mispredict redirect
//   train_valid/train_pc/train_taken                      predictor update
//   occupancy                                             queued entries
// -----------------------------------------------------------------------------
interface branch_resolver_if #(
    parameter int XLEN  = branch_pkg::XLEN_DEFAULT,
    parameter int DEPTH = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             pred_valid;
    logic             pred_ready;
    logic [XLEN-1:0]  pred_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;

    logic             res_valid;
    logic             res_taken;
    logic [XLEN-1:0]  res_target;

    logic             flush;
    logic [XLEN-1:0]  redirect_pc;
    logic             train_valid;
    logic [XLEN-1:0]  train_pc;
    logic             train_taken;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_target,
        output res_valid, res_taken, res_target,
        input  pred_ready, flush, redirect_pc,
        input  train_valid, train_pc, train_taken, occupancy
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_target,
        input  res_valid, res_taken, res_target,
        output pred_ready, flush, redirect_pc,
        output train_valid, train_pc, train_taken, occupancy
    );

endinterface

// File: rtl/br_fifo.sv
// -----------------------------------------------------------------------------
// br_fifo
// Circular in-order queue of DEPTH (power of two) entries, WIDTH bits each.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   push, din             write din at the tail (caller guarantees not full)
//   pop                   drop the head (caller guarantees not empty)
//   clear                 empty the queue; overrides push/pop
//   dout                  current head entry
//   occupancy             number of stored entries
// Entry storage is not reset; only pointers and occupancy are.
// -----------------------------------------------------------------------------
module br_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
// Keeps fetch-side predictions in program order, checks each execute-side
// resolution against the oldest one, emits a predictor training strobe for
// every resolved branch and a one-cycle flush with the correct next PC when
// the predicted next PC differs from the actual next PC.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   bus          branch_resolver_if.slave (prediction, resolution, results)
//   stat_branches, stat_mispredicts   32-bit saturating counters, present only
//                when BRANCH_RESOLVER_STATS_EN is defined
// Optional feature macro: BRANCH_RESOLVER_STATS_EN
// -----------------------------------------------------------------------------
module branch_resolver
    import branch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    branch_resolver_if.slave   bus
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts
`endif
);

    localparam int                OCC_W    = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
    } entry_t;

    br_state_e        state;
    entry_t           head;
    entry_t           push_entry;
    logic [OCC_W-1:0] occ;
    logic             ready;
    logic             resolve;
    logic             mispredict;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  predicted_pc;
    logic [XLEN-1:0]  correct_pc;

    // Readiness depends only on registered state, so fetch sees no
    // combinational path from its own inputs.
    assign ready          = (occ < OCC_FULL) && (state == ST_NORMAL);
    assign bus.pred_ready = ready;
    assign bus.occupancy  = occ;

    assign push_entry = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};

    always_comb begin
        seq_pc       = head.pc + XLEN'(INSN_BYTES);
        predicted_pc = head.taken   ? head.target    : seq_pc;
        correct_pc   = bus.res_taken ? bus.res_target : seq_pc;
        resolve      = bus.res_valid && (occ != '0) && (state == ST_NORMAL);
        // Only the next PC matters: a wrong direction whose taken target equals
        // the fall-through address still fetched the right path.
        mispredict   = resolve && (predicted_pc != correct_pc);
        pop          = resolve && !mispredict;
        // An entry offered alongside a mispredict is on the wrong path.
        push         = bus.pred_valid && ready && !mispredict;
    end

    br_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (mispredict),
        .din       (push_entry),
        .dout      (head),
        .occupancy (occ)
    );

    // FSM and registered result outputs. flush and train_valid are single-cycle
    // strobes; redirect_pc and train_pc/train_taken hold their last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_NORMAL;
            bus.flush       <= 1'b0;
            bus.redirect_pc <= '0;
            bus.train_valid <= 1'b0;
            bus.train_pc    <= '0;
            bus.train_taken <= 1'b0;
        end else begin
            bus.flush       <= 1'b0;
            bus.train_valid <= 1'b0;
            case (state)
                ST_NORMAL: begin
                    if (resolve) begin
                        bus.train_valid <= 1'b1;
                        bus.train_pc    <= head.pc;
                        bus.train_taken <= bus.res_taken;
                    end
                    if (mispredict) begin
                        bus.flush       <= 1'b1;
                        bus.redirect_pc <= correct_pc;
                        state           <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_NORMAL;
                end
                default: begin
                    state <= ST_NORMAL;
                end
            endcase
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve) begin
                stat_branches <= sat_inc(stat_branches);
            end
            if (mispredict) begin
                stat_mispredicts <= sat_inc(stat_mispredicts);
            end
        end
    end
`endif

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Back-end counterpart to the fetch-side branch predictor. Fetch enqueues every predicted control-flow instruction (PC, predicted direction, predicted target) into an in-order queue. Execute resolves branches in program order: the block compares each resolution against the oldest queued prediction, trains the direction predictor, and on a mismatch issues a one-cycle pipeline flush with the correct redirect PC, discarding all younger wrong-path entries.

## Interface
- DEPTH, 4, number of in-flight predictions tracked; power of two, ≥2
- XLEN, 64, PC width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high
- pred_valid  input  1  fetch offers a prediction this cycle
- pred_ready  output  1  queue accepts a prediction this cycle
- pred_pc  input  XLEN  PC of the predicted instruction
- pred_taken  input  1  predicted direction
- pred_target  input  XLEN  predicted taken target (PC+imm)
- res_valid  input  1  execute resolves the oldest branch this cycle
- res_taken  input  1  actual direction
- res_target  input  XLEN  actual taken target
- flush  output  1  one-cycle mispredict pulse
- redirect_pc  output  XLEN  correct next PC, valid while flush=1
- train_valid  output  1  one-cycle predictor update strobe
- train_pc  output  XLEN  PC of resolved branch
- train_taken  output  1  actual direction for training
- occupancy  output  $clog2(DEPTH+1)  queued entries

## Operation
- Enqueue on pred_valid && pred_ready; entry = {pc, taken, target}.
- Resolve when res_valid=1 and queue non-empty, against the head entry:
  - predicted_pc = taken ? target : pc+4 (mod 2^XLEN); correct_pc = res_taken ? res_target : pc+4.
  - Mismatch iff predicted_pc ≠ correct_pc (a wrong direction with equal targets is not a mispredict).
  - Head always dequeued; train_valid/train_pc/train_taken driven from that entry and res_taken.
- FSM: NORMAL, FLUSH.
  - NORMAL→FLUSH on a mispredicting resolve: whole queue cleared (occupancy→0), flush=1, redirect_pc=correct_pc.
  - FLUSH→NORMAL unconditionally after one cycle.
- pred_ready = (occupancy < DEPTH) && state==NORMAL; no full-bypass.
- Boundaries:
  - Simultaneous enqueue and correct resolve: both take effect, occupancy unchanged.
  - Simultaneous enqueue and mispredicting resolve: enqueued entry discarded (wrong path).
  - res_valid while empty: ignored, no train, no flush.
  - res_valid or pred_valid during FLUSH: ignored.
  - Pointers wrap modulo DEPTH.
- Reset: state=NORMAL, pointers and occupancy 0, flush=0, train_valid=0, redirect_pc=0, train_pc=0, train_taken=0.

## Timing
- flush, redirect_pc, train_* registered: asserted the cycle after the resolving edge, for exactly one cycle.
- occupancy registered; reflects the edge's enqueue/dequeue/clear.
- pred_ready combinational from registered state only; no input-to-output path.
- Reset assertion mid-flush clears flush immediately (async).

## Configuration
- BRANCH_RESOLVER_STATS_EN defined: adds outputs stat_branches and stat_mispredicts (32-bit each, reset 0, saturating at 2^32-1), incremented on each accepted resolve / each mispredict.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package branch_pkg: XLEN default, instruction-size constant 4, prediction-entry typedef {pc, taken, target}, FSM state enum.
- One sub-module br_fifo: parameterised circular queue with push, pop, clear, occupancy; the resolver holds the compare logic, FSM, and output registers.

## Test plan
- Enqueue pc=0x100/taken=1/target=0x140; resolve taken, 0x140 → next cycle train_valid=1, train_pc=0x100, train_taken=1, flush=0, occupancy 1→0.
- Enqueue 3 entries; resolve first not-taken against taken prediction → next cycle flush=1, redirect_pc=head pc+4, occupancy=0, pred_ready=0 for one cycle.
- Fill DEPTH=4 → pred_ready=0; same-cycle correct resolve and enqueue at occupancy 3 → occupancy stays 3.
- Mispredict resolve with pred_valid=1 the same cycle → new entry dropped, occupancy=0; res_valid on empty queue → no train, no flush.
- Pointer wrap: 10 enqueue/resolve pairs → all trains match enqueue order; reset asserted during flush cycle → flush drops asynchronously, all outputs 0.
- With BRANCH_RESOLVER_STATS_EN: 5 resolves including 2 mispredicts → stat_branches=5, stat_mispredicts=2.
